// File: rtl/pwm_duty_meter.sv
// Three-channel PWM high-time / period meter with stuck-level detection.
// Optional 2-flop input synchronizers are enabled by defining PWM_DUTY_METER_SYNC_EN.
`timescale 1ns/1ps
module pwm_duty_meter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 R_pwm_in,
    input  logic                 G_pwm_in,
    input  logic                 B_pwm_in,
    output logic [3*CNT_W-1:0]   high_o,
    output logic [3*CNT_W-1:0]   period_o,
    output logic [2:0]           valid_o,
    output logic [2:0]           stuck_o
);

    localparam int unsigned NCH = 3;
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } state_t;

    logic [NCH-1:0] pin;
    logic [NCH-1:0] pin_sync;
    logic [NCH-1:0] s;
    logic [NCH-1:0] s_d;

    assign pin = {B_pwm_in, G_pwm_in, R_pwm_in};

`ifdef PWM_DUTY_METER_SYNC_EN
    logic [NCH-1:0] sync_q1;
    logic [NCH-1:0] sync_q2;

    // Metastability guard for asynchronous PWM pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= pin;
            sync_q2 <= sync_q1;
        end
    end

    assign pin_sync = sync_q2;
`else
    assign pin_sync = pin;
`endif

    // Sample register and its one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s   <= '0;
            s_d <= '0;
        end else begin
            s   <= pin_sync;
            s_d <= s;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] pcnt;
        logic [CNT_W-1:0] pcnt_nxt;
        logic [CNT_W-1:0] hcnt;
        logic [CNT_W-1:0] hcnt_nxt;
        logic [CNT_W-1:0] high_q;
        logic [CNT_W-1:0] high_nxt;
        logic [CNT_W-1:0] period_q;
        logic [CNT_W-1:0] period_nxt;
        logic             valid_q;
        logic             valid_nxt;
        logic             stuck_q;
        logic             stuck_nxt;
        logic             rise;

        assign rise = s[g] & ~s_d[g];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state    <= SEEK;
                pcnt     <= '0;
                hcnt     <= '0;
                high_q   <= '0;
                period_q <= '0;
                valid_q  <= 1'b0;
                stuck_q  <= 1'b0;
            end else begin
                state    <= state_nxt;
                pcnt     <= pcnt_nxt;
                hcnt     <= hcnt_nxt;
                high_q   <= high_nxt;
                period_q <= period_nxt;
                valid_q  <= valid_nxt;
                stuck_q  <= stuck_nxt;
            end
        end

        // pcnt doubles as the SEEK timeout counter; counters saturate into STUCK instead of wrapping.
        always_comb begin
            state_nxt  = state;
            pcnt_nxt   = pcnt;
            hcnt_nxt   = hcnt;
            high_nxt   = high_q;
            period_nxt = period_q;
            valid_nxt  = 1'b0;
            stuck_nxt  = stuck_q;

            unique case (state)
                SEEK: begin
                    if (rise) begin
                        state_nxt = MEAS;
                        pcnt_nxt  = ONE;
                        hcnt_nxt  = ONE;
                    end else if (pcnt == MAX) begin
                        state_nxt  = STUCK;
                        high_nxt   = s[g] ? MAX : '0;
                        period_nxt = MAX;
                        valid_nxt  = 1'b1;
                        stuck_nxt  = 1'b1;
                    end else begin
                        pcnt_nxt = pcnt + ONE;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        high_nxt   = hcnt;
                        period_nxt = pcnt;
                        valid_nxt  = 1'b1;
                        pcnt_nxt   = ONE;
                        hcnt_nxt   = ONE;
                    end else if (pcnt == MAX) begin
                        state_nxt  = STUCK;
                        high_nxt   = s[g] ? MAX : '0;
                        period_nxt = MAX;
                        valid_nxt  = 1'b1;
                        stuck_nxt  = 1'b1;
                    end else begin
                        pcnt_nxt = pcnt + ONE;
                        hcnt_nxt = hcnt + CNT_W'(s[g]);
                    end
                end
                STUCK: begin
                    // The interval ending at the recovery rise is partial, so it is not reported.
                    if (rise) begin
                        state_nxt = MEAS;
                        pcnt_nxt  = ONE;
                        hcnt_nxt  = ONE;
                        stuck_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = SEEK;
                    pcnt_nxt  = '0;
                    hcnt_nxt  = '0;
                end
            endcase
        end

        assign high_o[g*CNT_W +: CNT_W]   = high_q;
        assign period_o[g*CNT_W +: CNT_W] = period_q;
        assign valid_o[g]                 = valid_q;
        assign stuck_o[g]                 = stuck_q;
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: per-channel waveform generators push expected
// measurements; a negedge monitor pops them whenever a valid strobe appears.
`timescale 1ns/1ps
module tb_pwm_duty_meter;

`ifdef PWM_DUTY_METER_SYNC_EN
    localparam longint LAT = 4;
`else
    localparam longint LAT = 2;
`endif

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  pins    = 3'b000;
    logic [23:0] high_o;
    logic [23:0] period_o;
    logic [2:0]  valid_o;
    logic [2:0]  stuck_o;

    pwm_duty_meter #(.CNT_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .R_pwm_in (pins[0]),
        .G_pwm_in (pins[1]),
        .B_pwm_in (pins[2]),
        .high_o   (high_o),
        .period_o (period_o),
        .valid_o  (valid_o),
        .stuck_o  (stuck_o)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    typedef struct {
        int     high;
        int     period;
        bit     stuck;
        longint at;      // expected cycle of the valid strobe, -1 = any
    } exp_t;

    exp_t q[3][$];

    int cfg_hi[3];
    int cfg_per[3];
    int cfg_ph[3];
    int nrise[3];
    bit prev[3];
    int tick = 0;

    // per == 0 means a constant level given by hi.
    function automatic bit wave(int c, int t);
        if (cfg_per[c] == 0) return cfg_hi[c] != 0;
        return ((t + cfg_ph[c]) % cfg_per[c]) < cfg_hi[c];
    endfunction

    task automatic set_ch(int c, int hi, int per, int ph);
        cfg_hi[c]  = hi;
        cfg_per[c] = per;
        cfg_ph[c]  = ph;
        nrise[c]   = 0;
    endtask

    task automatic push_stuck(int c, int hi);
        exp_t e;
        e.high   = hi;
        e.period = 255;
        e.stuck  = 1'b1;
        e.at     = -1;
        q[c].push_back(e);
    endtask

    // Drive n cycles; every rise after the first on a channel expects a full-period report.
    task automatic run(int n);
        bit   v;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 3; c++) begin
                v = wave(c, tick);
                if (v && !prev[c]) begin
                    if (nrise[c] > 0) begin
                        e.high   = cfg_hi[c];
                        e.period = cfg_per[c];
                        e.stuck  = 1'b0;
                        e.at     = cyc + LAT;
                        q[c].push_back(e);
                    end
                    nrise[c]++;
                end
                prev[c] = v;
                pins[c] = v;
            end
            tick++;
        end
    endtask

    exp_t       mon_e;
    logic [7:0] mon_h;
    logic [7:0] mon_p;

    always @(negedge clk) begin
        if (armed && reset_n) begin
            for (int c = 0; c < 3; c++) begin
                if (valid_o[c]) begin
                    checks++;
                    mon_h = high_o[c*8 +: 8];
                    mon_p = period_o[c*8 +: 8];
                    if (q[c].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid ch%0d cyc=%0d: got high=%0d period=%0d stuck=%0b, want no valid",
                                 c, cyc, mon_h, mon_p, stuck_o[c]);
                    end else begin
                        mon_e = q[c].pop_front();
                        if (int'(mon_h) != mon_e.high || int'(mon_p) != mon_e.period ||
                            stuck_o[c] !== mon_e.stuck || (mon_e.at >= 0 && cyc != mon_e.at)) begin
                            errors++;
                            $display("FAIL measurement ch%0d: got high=%0d period=%0d stuck=%0b cyc=%0d, want high=%0d period=%0d stuck=%0b cyc=%0d",
                                     c, mon_h, mon_p, stuck_o[c], cyc,
                                     mon_e.high, mon_e.period, mon_e.stuck, mon_e.at);
                        end
                    end
                end
            end
        end
    end

    // Assert reset between edges and confirm outputs clear without a clock edge.
    task automatic do_reset(string name);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        pins    = 3'b000;
        #1;
        checks++;
        if (high_o !== 24'h0) begin
            errors++;
            $display("FAIL %s_high: got %h, want 0", name, high_o);
        end
        checks++;
        if (period_o !== 24'h0) begin
            errors++;
            $display("FAIL %s_period: got %h, want 0", name, period_o);
        end
        checks++;
        if (valid_o !== 3'b000) begin
            errors++;
            $display("FAIL %s_valid: got %b, want 000", name, valid_o);
        end
        checks++;
        if (stuck_o !== 3'b000) begin
            errors++;
            $display("FAIL %s_stuck: got %b, want 000", name, stuck_o);
        end
        for (int c = 0; c < 3; c++) begin
            q[c].delete();
            prev[c] = 1'b0;
            set_ch(c, 0, 0, 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        armed   = 1'b1;
        tick    = 0;
    endtask

    task automatic end_check(string name);
        repeat (int'(LAT) + 3) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (q[c].size() != 0) begin
                errors++;
                $display("FAIL %s_pending ch%0d: %0d expected valids not seen, want 0", name, c, q[c].size());
            end
        end
    endtask

    task automatic test_reset();
        do_reset("reset_initial");
    endtask

    task automatic test_basic();
        do_reset("reset_basic");
        set_ch(0, 50, 200, 50);
        push_stuck(1, 0);
        push_stuck(2, 0);
        run(800);
        end_check("basic");
    endtask

    task automatic test_stuck();
        do_reset("reset_stuck");
        set_ch(0, 0, 0, 0);
        set_ch(1, 1, 0, 0);
        set_ch(2, 1, 2, 1);
        push_stuck(0, 0);
        push_stuck(1, 255);
        run(300);
        checks++;
        if (stuck_o !== 3'b011) begin
            errors++;
            $display("FAIL stuck_flags: got %b, want 011", stuck_o);
        end
        end_check("stuck");
    endtask

    task automatic test_recovery();
        checks++;
        if (stuck_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL recovery_pre: got G stuck=%b, want 1", stuck_o[1]);
        end
        set_ch(1, 10, 40, 10);
        set_ch(2, 0, 0, 0);
        tick = 0;
        run(40);
        checks++;
        if (stuck_o !== 3'b001) begin
            errors++;
            $display("FAIL recovery_clear: got %b, want 001", stuck_o);
        end
        run(100);
        end_check("recovery");
    endtask

    task automatic test_independence();
        do_reset("reset_indep");
        set_ch(0, 20, 200, 20);
        set_ch(1, 180, 200, 180);
        set_ch(2, 100, 200, 100);
        run(700);
        end_check("indep");
    endtask

    task automatic test_min_period();
        do_reset("reset_minper");
        for (int c = 0; c < 3; c++) set_ch(c, 1, 2, 1);
        run(20);
        end_check("minper");
    endtask

    task automatic test_max_period();
        do_reset("reset_maxper");
        set_ch(0, 100, 255, 100);
        set_ch(1, 200, 255, 200);
        set_ch(2, 254, 255, 254);
        run(800);
        end_check("maxper");
        checks++;
        if (stuck_o !== 3'b000) begin
            errors++;
            $display("FAIL maxper_stuck: got %b, want 000", stuck_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset("reset_mid_a");
        set_ch(0, 50, 200, 50);
        run(200);
        do_reset("reset_mid_b");
        set_ch(0, 50, 200, 50);
        push_stuck(1, 0);
        push_stuck(2, 0);
        run(400);
        end_check("reset_mid");
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin
            prev[c] = 1'b0;
            set_ch(c, 0, 0, 0);
        end
        test_reset();
        test_basic();
        test_stuck();
        test_recovery();
        test_independence();
        test_min_period();
        test_max_period();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
- Three-channel PWM measurement block. It is the receiving end of the RGB PWM drive.
- It samples the R/G/B PWM waveforms and measures each channel's high time and period in clock cycles, counted from rising edge to rising edge.
- It reports each measurement with a one-cycle valid strobe and flags channels stuck at a constant level.
- Used for on-board self-check and for feeding measured duty back to the colour sequencer.

Parameters:
- CNT_W, 8: width of the high and period counters. MAX = 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- R_pwm_in  in  1  red PWM waveform.
- G_pwm_in  in  1  green PWM waveform.
- B_pwm_in  in  1  blue PWM waveform.
- high_o  out  3*CNT_W  measured high cycles. R=[CNT_W-1:0], G=next CNT_W bits, B=top CNT_W bits.
- period_o  out  3*CNT_W  measured period cycles, same packing as high_o.
- valid_o  out  3  one-cycle strobe per channel when that channel's high/period fields update. Bit0=R, bit1=G, bit2=B.
- stuck_o  out  3  level flag per channel: no rising edge seen within MAX cycles.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0.
  - sample registers 0.
  - all counters 0.
  - every channel FSM in SEEK.
- Per channel, the three channels are identical and fully independent:
  - s is the registered pin; s_d is the previous s.
  - rise = s & ~s_d.
- FSM states: SEEK, MEAS, STUCK.
- SEEK:
  - cnt increments each cycle.
  - On rise: go to MEAS with period_cnt=1, high_cnt=1. No valid.
  - If cnt==MAX and no rise: go to STUCK.
- MEAS, each cycle without rise:
  - period_cnt+1.
  - high_cnt+s.
- MEAS, on rise:
  - Register high_o field = high_cnt and period_o field = period_cnt (pre-update values).
  - Pulse valid for 1 cycle.
  - Reload both counters to 1.
- MEAS, period_cnt==MAX with no rise: go to STUCK.
- Entering STUCK:
  - high field = all-ones if s=1, else 0.
  - period field = MAX.
  - stuck=1.
  - valid pulses once.
  - Fields are frozen while in STUCK; no further valid, including on a falling edge.
- STUCK, on rise:
  - go to MEAS with counters=1.
  - stuck cleared in the same cycle.
  - no valid; the interval is invalid.
  - The next valid comes after one full period.
- Counters never wrap; MAX is the timeout bound. A period of exactly MAX cycles is reported normally.
- Latency: pin rising edge to valid high = 2 clk edges (1 sample register + 1 output register).
- Measurement accuracy is ±0 cycles for synchronous inputs.
- Simultaneous rises on several channels produce simultaneous valid bits.
- Reset mid-measurement:
  - partial counts are discarded.
  - the FSM returns to SEEK.
  - the first rise after reset gives no valid.

Optional Feature:
- Macro: PWM_DUTY_METER_SYNC_EN.
- Defined: each pin passes through a 2-flop synchronizer, reset to 0, before the sample register. Pin-to-valid latency becomes 4 clk edges. Measured values are unchanged.
- Undefined: inputs are assumed synchronous to clk; no synchronizers are added.

Test Plan:
- Reset: assert reset_n=0 mid-run -> high_o=0, period_o=0, valid_o=0, stuck_o=0 immediately, without waiting for a clk edge.
- R: 50 cycles high, 150 cycles low, repeated:
  - no valid on the first rise.
  - on each later rise, R valid pulses 1 cycle with R high=50, R period=200.
  - valid appears 2 edges after the pin rise.
- Constant inputs from reset (R=0, G=1, B toggling):
  - after MAX cycles, R stuck=1, high=0, period=255, one valid.
  - G stuck=1, high=255, period=255, one valid.
  - B never stuck.
- Independence: R 20/200, G 180/200, B 100/200, phase-shifted -> each field reports its own values. Valids coincide only when rises coincide.
- Minimum period: pin toggling every clock -> high=1, period=2 on every rise. Period exactly 255 -> reported normally, stuck=0.
- Recovery: G stuck, then 10/40 PWM applied:
  - stuck clears at the first rise, with no valid.
  - the next rise gives valid with high=10, period=40.
- Reset mid-period: reset, then the next rise gives no valid; the following rise gives the correct values.
